// File: rtl/ex_muldiv_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
// Start/Op/operands/Cancel flow in; Busy/Done stall and retire; HiOut/LoOut carry HI/LO.
interface ex_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic             Cancel;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HiOut;
  logic [WIDTH-1:0] LoOut;

  modport master (
    output Start, Op, Operand1, Operand2, Cancel,
    input  Busy, Done, HiOut, LoOut
  );

  modport slave (
    input  Start, Op, Operand1, Operand2, Cancel,
    output Busy, Done, HiOut, LoOut
  );
endinterface

// File: rtl/ex_muldiv.sv
// HI/LO multiply (MUL_LATENCY cycles, pipelined) and restoring divide (WIDTH+2 cycles).
// Busy stalls the pipe; Start is only taken in IDLE/DONE; Cancel flushes to IDLE.
module ex_muldiv #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 3
) (
  input  logic       clk,
  input  logic       reset,
  ex_muldiv_if.slave bus
);
  localparam int CW = $clog2((WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY) + 1;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  state_t state, state_n;

  logic               accept;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic [2*WIDTH-1:0] pipe [0:MUL_LATENCY-2];
  logic               op1_neg, op2_neg;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH-1:0]   dvd_raw, dvs, quo, rem;
  logic               q_neg, r_neg;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   diff;
  logic               ge;
  logic [WIDTH-1:0]   q_fix, r_fix;
  logic [WIDTH-1:0]   hi_q, lo_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    if (bus.Cancel) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          state_n = IDLE;
          if (bus.Start) begin
            accept  = 1'b1;
            state_n = bus.Op[1] ? DIV : MUL;
          end
        end
        MUL:     if (cnt == CW'(MUL_LATENCY - 2)) state_n = DONE;
        DIV:     if (cnt == CW'(WIDTH - 1)) state_n = FIX;
        FIX:     state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
    bus.Busy = (state == MUL) || (state == DIV) || (state == FIX);
    bus.Done = (state == DONE);
  end

  // Op[0] set means unsigned; the same sign bits drive both the multiply extension and divide magnitudes.
  assign op1_neg = ~bus.Op[0] & bus.Operand1[WIDTH-1];
  assign op2_neg = ~bus.Op[0] & bus.Operand2[WIDTH-1];
  assign a_ext   = {{WIDTH{op1_neg}}, bus.Operand1};
  assign b_ext   = {{WIDTH{op2_neg}}, bus.Operand2};
  assign prod    = a_ext * b_ext;
  assign mag1    = op1_neg ? -bus.Operand1 : bus.Operand1;
  assign mag2    = op2_neg ? -bus.Operand2 : bus.Operand2;

  // rem < dvs always holds, so a successful trial difference fits in WIDTH bits.
  assign shifted = {rem, quo[WIDTH-1]};
  assign ge      = shifted >= {1'b0, dvs};
  assign diff    = shifted[WIDTH-1:0] - dvs;

  always_comb begin
    q_fix = q_neg ? -quo : quo;
    r_fix = r_neg ? -rem : rem;
    if (dvs == '0) begin
      q_fix = '1;
      r_fix = dvd_raw;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      dvd_raw <= '0;
      dvs     <= '0;
      quo     <= '0;
      rem     <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      for (int i = 0; i < MUL_LATENCY - 1; i++) pipe[i] <= '0;
    end else begin
      for (int i = 1; i < MUL_LATENCY - 1; i++) pipe[i] <= pipe[i-1];
      if (accept) begin
        cnt     <= '0;
        dvd_raw <= bus.Operand1;
        dvs     <= mag2;
        quo     <= mag1;
        rem     <= '0;
        q_neg   <= op1_neg ^ op2_neg;
        r_neg   <= op1_neg;
        if (!bus.Op[1]) pipe[0] <= prod;
      end else begin
        if (state == MUL || state == DIV) cnt <= cnt + 1'b1;
        if (state == DIV) begin
          quo <= {quo[WIDTH-2:0], ge};
          rem <= ge ? diff : shifted[WIDTH-1:0];
        end
      end
      if (state_n == DONE && state == MUL) begin
        hi_q <= pipe[MUL_LATENCY-2][2*WIDTH-1:WIDTH];
        lo_q <= pipe[MUL_LATENCY-2][WIDTH-1:0];
      end else if (state_n == DONE && state == FIX) begin
        hi_q <= r_fix;
        lo_q <= q_fix;
      end
    end
  end

  assign bus.HiOut = hi_q;
  assign bus.LoOut = lo_q;
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Multi-cycle multiply/divide unit that sits beside the execute stage and produces HI/LO results for MULT, MULTU, DIV and DIVU. It replaces single-cycle combinational multiplication with a pipelined multiply of configurable latency and an iterative restoring divider. It is parametrised in operand width. It stalls the pipeline through a busy/done handshake and supports flushing of an in-flight operation on exception.

## Interface
Parameters:
- WIDTH, 32, operand and result width in bits (>= 4).
- MUL_LATENCY, 3, cycles from the accepting edge to Done for multiplies (>= 2).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- Start  input  1  request an operation; sampled only while the unit is idle or done.
- Op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with Start.
- Operand1  input  WIDTH  multiplicand or dividend (rs); captured with Start.
- Operand2  input  WIDTH  multiplier or divisor (rt); captured with Start.
- Cancel  input  1  synchronous flush of any in-flight operation.
- Busy  output  1  operation in progress; the pipeline stalls while it is high.
- Done  output  1  one-cycle pulse; HiOut/LoOut are valid and the HI/LO write is due.
- HiOut  output  WIDTH  upper product half, or remainder.
- LoOut  output  WIDTH  lower product half, or quotient.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE. Reset forces IDLE with Busy=0, Done=0, HiOut=0, LoOut=0, and clears all internal registers.
- Start is accepted in IDLE or DONE. On acceptance, operands and Op are registered, so later input changes have no effect. Start is ignored in MUL, DIV and FIX.
- MULT/MULTU:
  - IDLE→MUL. The full 2*WIDTH product is computed through a MUL_LATENCY-1 stage register chain.
  - MULT treats operands as two's complement; MULTU treats them as unsigned.
  - MUL→DONE once the chain has advanced MUL_LATENCY-1 times.
  - Hi = product[2W-1:W]; Lo = product[W-1:0].
- DIV/DIVU:
  - IDLE→DIV. For DIV, operand magnitudes and result signs are recorded. The unit then performs WIDTH restoring iterations, one quotient bit per cycle, driven by a log2(WIDTH)+1 bit counter. DIV→FIX after WIDTH cycles.
  - FIX applies signs: the quotient is truncated toward zero and the remainder takes the dividend's sign. FIX→DONE.
  - Lo = quotient; Hi = remainder.
- Divide by zero (both ops): the iteration still runs full length. Result is Lo = all ones and Hi = Operand1 as captured.
- DIV of the most-negative value by -1: Lo = most-negative value (wraps), Hi = 0.
- DONE: Done=1 for exactly one cycle, then DONE→IDLE unless a new Start is accepted, which goes directly to MUL/DIV.
- HiOut/LoOut load only on entry to DONE and hold until the next DONE entry.
- Busy = 1 in MUL, DIV and FIX; otherwise 0.
- Cancel has the highest priority after reset. Any state goes to IDLE at the next edge, with no Done and HiOut/LoOut unchanged.
  - Cancel together with Start in IDLE/DONE: Start is discarded.
  - Cancel in DONE: Done is not suppressed for the current cycle; the next state is IDLE.
- Reset asserted mid-operation: the unit goes immediately to IDLE with all outputs zeroed, and no Done is issued.

## Timing
- Let E0 be the edge that accepts Start. Busy rises after E0.
- Multiply: Done is high in the cycle after edge E0+MUL_LATENCY-1, i.e. MUL_LATENCY cycles after Start was presented (3 for the default).
- Divide: Done is high in the cycle after edge E0+WIDTH+1 (33 for WIDTH=32). Busy is high for WIDTH+1 cycles.
- Busy and Done are never high together. Both are registered state decodes with no combinational path from any input.
- Back-to-back operation: Start presented during the Done cycle is accepted. Throughput is one operation per MUL_LATENCY cycles (multiply) or WIDTH+2 cycles (divide).

## Test plan
- MULT 0xFFFFFFFD × 0x00000005 → Done exactly 3 cycles after Start; Hi=0xFFFFFFFF, Lo=0xFFFFFFF1; Busy high for 2 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → Hi=0xFFFFFFFE, Lo=0x00000001. Operands changed the cycle after Start → result unchanged.
- DIV 0xFFFFFFF9 / 0x00000002 → Done at cycle 33; Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIVU 0x00000064 / 0 → Lo=0xFFFFFFFF, Hi=0x00000064. DIV 0x80000000 / 0xFFFFFFFF → Lo=0x80000000, Hi=0.
- DIVU in progress, Cancel at cycle 10 → IDLE, no Done, HiOut/LoOut keep previous values. Start MULTU 7×6 next cycle → Lo=42, Hi=0.
- Reset pulsed at cycle 5 of DIV → all outputs 0 immediately, no Done. Start during Busy → ignored. Start in the Done cycle → accepted back-to-back.
